// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker fetch stage.
package tinker_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 64;

   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 64'h2000;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RD_MSB  = 26;
   localparam int RD_LSB  = 22;
   localparam int RS_MSB  = 21;
   localparam int RS_LSB  = 17;
   localparam int RT_MSB  = 16;
   localparam int RT_LSB  = 12;
   localparam int L_MSB   = 11;
   localparam int L_LSB   = 0;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      WAIT   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
      return pc & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding {pc, instr} entries for the fetch stage.
module fetch_fifo
   import tinker_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  fetch_entry_t     i_entry,
   input  logic             i_pop,
   input  logic             i_flush,
   output fetch_entry_t     o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W-1:0] r_wr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_pop;
   logic             w_push;

   assign o_full  = (r_cnt == CNT_W'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   assign o_head  = r_mem[r_rd];

   // A push into a full buffer is only accepted when the head leaves in the same cycle.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_entry;
            r_wr        <= r_wr + PTR_W'(1);
         end
         if (w_pop) r_rd <= r_rd + PTR_W'(1);
         r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

endmodule

// File: rtl/tinker_fetch.sv
// Tinker instruction fetch: PC, single-outstanding memory reads, instruction buffer.
// Optional TINKER_FETCH_PERF_EN adds saturating fetch/redirect counters.
//
// state  | meaning
// RUN    | may issue a request (subject to buffer room)
// WAIT   | one request outstanding; r_drop discards its response
// HALTED | no issue until the next redirect
module tinker_fetch
   import tinker_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int                BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [ADDR_W-1:0]  mem_req_addr,
   input  logic               mem_rsp_valid,
   input  logic [INSTR_W-1:0] mem_rsp_data,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               halt
`ifdef TINKER_FETCH_PERF_EN
   ,
   output logic [31:0]        fetch_count,
   output logic [31:0]        redirect_count
`endif
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   fetch_state_t     r_state;
   logic [ADDR_W-1:0] r_pc;
   logic             r_req_valid;
   logic             r_drop;
   logic             r_halt;

   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_halt_seen;
   logic             w_outst_next;
   logic             w_room_next;
   logic             w_empty;
   logic             w_unused_full;
   logic [CNT_W-1:0] w_count;
   logic [CNT_W-1:0] w_cnt_next;
   fetch_entry_t     w_entry;
   fetch_entry_t     w_head;

   assign mem_req_valid = r_req_valid;
   assign mem_req_addr  = r_pc;

   assign w_accept     = r_req_valid & mem_req_ready;
   assign w_push       = (r_state == WAIT) & mem_rsp_valid & ~r_drop & ~redirect_valid;
   assign w_pop        = instr_valid & instr_ready & ~redirect_valid;
   assign w_halt_seen  = r_halt | halt;
   assign w_outst_next = ((r_state == WAIT) & ~mem_rsp_valid) | w_accept;
   assign w_cnt_next   = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_room_next  = (w_cnt_next < CNT_W'(BUF_DEPTH));

   // r_pc already advanced past the outstanding request when its response lands.
   assign w_entry = '{pc: r_pc - ADDR_W'(4), instr: mem_rsp_data};

   fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_entry (w_entry),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .o_head  (w_head),
      .o_full  (w_unused_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign instr_valid = ~w_empty;
   assign instr       = w_head.instr;
   assign instr_pc    = w_head.pc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= RUN;
         r_pc        <= RESET_PC;
         r_req_valid <= 1'b0;
         r_drop      <= 1'b0;
         r_halt      <= 1'b0;
      end else if (redirect_valid) begin
         r_pc   <= align_pc(redirect_pc);
         r_halt <= 1'b0;
         if (w_outst_next) begin
            r_state     <= WAIT;
            r_drop      <= 1'b1;
            r_req_valid <= 1'b0;
         end else begin
            r_state     <= RUN;
            r_drop      <= 1'b0;
            r_req_valid <= 1'b1;
         end
      end else begin
         r_halt <= w_halt_seen;
         case (r_state)
            RUN: begin
               if (w_accept) begin
                  r_pc        <= r_pc + ADDR_W'(4);
                  r_state     <= WAIT;
                  r_req_valid <= 1'b0;
               end else if (halt) begin
                  r_state     <= HALTED;
                  r_req_valid <= 1'b0;
               end else begin
                  r_req_valid <= w_room_next;
               end
            end
            WAIT: begin
               if (mem_rsp_valid) begin
                  r_drop <= 1'b0;
                  if (w_halt_seen) begin
                     r_state     <= HALTED;
                     r_req_valid <= 1'b0;
                  end else begin
                     r_state     <= RUN;
                     r_req_valid <= w_room_next;
                  end
               end
            end
            HALTED:  r_req_valid <= 1'b0;
            default: begin
               r_state     <= RUN;
               r_req_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef TINKER_FETCH_PERF_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_redir_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fetch_cnt <= '0;
         r_redir_cnt <= '0;
      end else begin
         if (w_push && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (redirect_valid && (r_redir_cnt != '1)) r_redir_cnt <= r_redir_cnt + 32'd1;
      end
   end

   assign fetch_count    = r_fetch_cnt;
   assign redirect_count = r_redir_cnt;
`endif

endmodule

// File: tb/tb_tinker_fetch.sv
// Self-checking bench for tinker_fetch: memory model, scoreboard and directed sequences.
module tb_tinker_fetch;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic [63:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        halt = 1'b0;
`ifdef TINKER_FETCH_PERF_EN
   logic [31:0] fetch_count;
   logic [31:0] redirect_count;
`endif

   tinker_fetch dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt)
`ifdef TINKER_FETCH_PERF_EN
      ,
      .fetch_count    (fetch_count),
      .redirect_count (redirect_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [63:0] rpc;
      logic [63:0] exp_addr;
      logic [63:0] exp_next;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   logic [63:0] popped[$];
   logic        sb_drop = 1'b0;
   logic [63:0] exp_pc = 64'h2000;
   logic [63:0] pend_addr = '0;
   logic [63:0] rsp_pc = '0;
   logic [63:0] last_acc_addr = '0;
   int          timer = 0;
   int          lat = 1;
   int          cyc = 0;
   int          n_acc = 0;
   int          exp_fetch = 0;
   int          exp_redir = 0;
   int          acc_log[$];

   function automatic logic [31:0] mkdata(input logic [63:0] a);
      return a[31:0] ^ 32'h5A5A_1234 ^ {a[17:2], 16'h0};
   endfunction

   function automatic logic [63:0] popped_at(input int i);
      return (popped.size() > i) ? popped[i] : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      logic        acc;
      logic        pop;
      logic [63:0] a;
      exp_t        e;
      acc = mem_req_valid && mem_req_ready && reset_n;
      pop = instr_valid && instr_ready && !redirect_valid && reset_n;
      a   = mem_req_addr;
      if (pop) begin
         if (sb.size() == 0) begin
            chk("unexpected_instr_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr", {32'h0, instr}, {32'h0, e.data});
            popped.push_back(instr_pc);
         end
      end
      if (acc) begin
         chk("req_addr", a, exp_pc);
         exp_pc = exp_pc + 64'd4;
         last_acc_addr = a;
         n_acc++;
         acc_log.push_back(cyc);
      end
      if (mem_rsp_valid && reset_n && !redirect_valid) begin
         if (sb_drop) sb_drop = 1'b0;
         else begin
            sb.push_back('{pc: rsp_pc, data: mem_rsp_data});
            exp_fetch++;
         end
      end
      if (redirect_valid && reset_n) begin
         sb.delete();
         sb_drop = (timer != 0) || acc;
         exp_pc = redirect_pc & ~64'h3;
         exp_redir++;
      end
      @(posedge clk);
      #1;
      cyc++;
      mem_rsp_valid = 1'b0;
      if (acc) begin
         timer = lat;
         pend_addr = a;
      end
      if (timer != 0) begin
         timer--;
         if (timer == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mkdata(pend_addr);
            rsp_pc        = pend_addr;
         end
      end
      chk("instr_valid", {63'h0, instr_valid}, {63'h0, (sb.size() != 0)});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      redirect_valid = 1'b0;
      halt = 1'b0;
      mem_rsp_valid = 1'b0;
      timer = 0;
      sb.delete();
      popped.delete();
      acc_log.delete();
      sb_drop = 1'b0;
      exp_pc = 64'h2000;
      n_acc = 0;
      exp_fetch = 0;
      exp_redir = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic send_redirect(input logic [63:0] pc);
      redirect_valid = 1'b1;
      redirect_pc = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   vec_t vecs[4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int n;
      vecs[0] = '{rpc: 64'h4000,                exp_addr: 64'h4000,                exp_next: 64'h4004};
      vecs[1] = '{rpc: 64'h3003,                exp_addr: 64'h3000,                exp_next: 64'h3004};
      vecs[2] = '{rpc: 64'h0000_0001_2345_6786, exp_addr: 64'h0000_0001_2345_6784, exp_next: 64'h0000_0001_2345_6788};
      vecs[3] = '{rpc: 64'hFFFF_FFFF_FFFF_FFFD, exp_addr: 64'hFFFF_FFFF_FFFF_FFFC, exp_next: 64'h0};

      // Reset values and first request
      @(posedge clk);
      #1;
      chk("rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
      chk("rst_req_addr", mem_req_addr, 64'h2000);
      chk("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
      chk("rst_instr", {32'h0, instr}, 64'h0);
      chk("rst_instr_pc", instr_pc, 64'h0);
      lat = 1;
      mem_req_ready = 1'b1;
      instr_ready = 1'b1;
      do_reset();
      chk("pre_first_req_valid", {63'h0, mem_req_valid}, 64'h0);
      tick();
      chk("first_req_valid", {63'h0, mem_req_valid}, 64'h1);
      chk("first_req_addr", mem_req_addr, 64'h2000);
      n = 0;
      while (popped.size() < 3 && n < 40) begin tick(); n++; end
      chk("seq_pc0", popped_at(0), 64'h2000);
      chk("seq_pc1", popped_at(1), 64'h2004);
      chk("seq_pc2", popped_at(2), 64'h2008);
      if (acc_log.size() >= 3) begin
         chk("throughput01", 64'(acc_log[1] - acc_log[0]), 64'(lat + 1));
         chk("throughput12", 64'(acc_log[2] - acc_log[1]), 64'(lat + 1));
      end else chk("throughput_accepts", 64'(acc_log.size()), 64'd3);

      // Backpressure: buffer fills, issue stops, then resumes
      instr_ready = 1'b0;
      do_reset();
      repeat (12) tick();
      chk("bp_accepts", 64'(n_acc), 64'd2);
      chk("bp_req_valid", {63'h0, mem_req_valid}, 64'h0);
      instr_ready = 1'b1;
      tick();
      chk("bp_first_pop", popped_at(0), 64'h2000);
      chk("bp_resume_valid", {63'h0, mem_req_valid}, 64'h1);
      repeat (8) tick();

      // Redirect while a request is outstanding
      lat = 3;
      do_reset();
      n = 0;
      while (!(n_acc >= 2 && last_acc_addr == 64'h2004) && n < 50) begin tick(); n++; end
      chk("redir_out_reached", last_acc_addr, 64'h2004);
      send_redirect(64'h3002);
      chk("redir_out_wait", {63'h0, mem_req_valid}, 64'h0);
      n = 0;
      while (n_acc < 3 && n < 30) begin tick(); n++; end
      chk("redir_out_addr", last_acc_addr, 64'h3000);
      repeat (10) tick();
      n = 0;
      foreach (popped[i]) if (popped[i] == 64'h2004) n++;
      chk("redir_no_2004", 64'(n), 64'd0);
      chk("redir_pop1", popped_at(1), 64'h3000);

      // Redirect with same-cycle response and consumer handshake
      lat = 1;
      instr_ready = 1'b0;
      do_reset();
      n = 0;
      while (!(mem_rsp_valid && instr_valid) && n < 30) begin tick(); n++; end
      chk("same_setup", {63'h0, instr_valid}, 64'h1);
      instr_ready = 1'b1;
      send_redirect(64'h5000);
      chk("same_empty", {63'h0, instr_valid}, 64'h0);
      chk("same_req_valid", {63'h0, mem_req_valid}, 64'h1);
      chk("same_req_addr", mem_req_addr, 64'h5000);
      repeat (10) tick();
      chk("same_first_pop", popped_at(0), 64'h5000);

      // Halt during WAIT
      lat = 3;
      do_reset();
      n = 0;
      while (n_acc < 1 && n < 30) begin tick(); n++; end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      repeat (15) tick();
      chk("halt_accepts", 64'(n_acc), 64'd1);
      chk("halt_req_valid", {63'h0, mem_req_valid}, 64'h0);
      chk("halt_pops", 64'(popped.size()), 64'd1);
      chk("halt_pop_pc", popped_at(0), 64'h2000);
      send_redirect(64'h4000);
      chk("halt_resume_valid", {63'h0, mem_req_valid}, 64'h1);
      chk("halt_resume_addr", mem_req_addr, 64'h4000);
      repeat (6) tick();

      // Redirect alignment and PC wrap from the halted state
      for (int v = 0; v < 4; v++) begin
         halt = 1'b1;
         mem_req_ready = 1'b0;
         repeat (8) tick();
         halt = 1'b0;
         send_redirect(vecs[v].rpc);
         chk($sformatf("vec%0d_valid", v), {63'h0, mem_req_valid}, 64'h1);
         chk($sformatf("vec%0d_addr", v), mem_req_addr, vecs[v].exp_addr);
         mem_req_ready = 1'b1;
         tick();
         mem_req_ready = 1'b0;
         chk($sformatf("vec%0d_next", v), mem_req_addr, vecs[v].exp_next);
      end
      repeat (6) tick();
      mem_req_ready = 1'b1;

`ifdef TINKER_FETCH_PERF_EN
      lat = 1;
      instr_ready = 1'b1;
      do_reset();
      n = 0;
      while (exp_fetch < 3 && n < 40) begin tick(); n++; end
      send_redirect(64'h6000);
      send_redirect(64'h6100);
      n = 0;
      while (exp_fetch < 5 && n < 40) begin tick(); n++; end
      mem_req_ready = 1'b0;
      halt = 1'b1;
      repeat (6) tick();
      halt = 1'b0;
      chk("perf_fetch", {32'h0, fetch_count}, 64'd5);
      chk("perf_redir", {32'h0, redirect_count}, 64'd2);
      mem_req_ready = 1'b1;
      send_redirect(64'h2100);
      repeat (5) tick();
`endif

      // Reset mid-run takes effect without a clock edge
      reset_n = 1'b0;
      #1;
      chk("mid_rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
      chk("mid_rst_addr", mem_req_addr, 64'h2000);
      chk("mid_rst_instr_valid", {63'h0, instr_valid}, 64'h0);
      chk("mid_rst_instr_pc", instr_pc, 64'h0);
`ifdef TINKER_FETCH_PERF_EN
      chk("mid_rst_fetch_cnt", {32'h0, fetch_count}, 64'h0);
      chk("mid_rst_redir_cnt", {32'h0, redirect_count}, 64'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
